shift_req_stage: RTL and testbench



---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_req_stage_if.sv | 37 +++
 rtl/shift_req_fifo.sv | 67 ++++++
 rtl/shift_req_stage.sv | 66 ++++++
 tb/tb_shift_req_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the barrel-shifter request stage.
//   shift_dir_t : request direction (right = 0, left = 1)
//   AMT_W       : width of the shift-amount field on the request bus
//   norm_amt()  : folds any 8-bit amount plus direction into a rotate-right
//                 count in 0..n-1 (n must be a power of two)
package shift_pkg;

  localparam int AMT_W = 8;

  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_t;

  // A left rotate by m equals a right rotate by (n - m) mod n. The final
  // mask makes m = 0 map to 0 instead of n.
  function automatic logic [AMT_W-1:0] norm_amt(input logic [AMT_W-1:0] amt,
                                                input shift_dir_t       dir,
                                                input int unsigned      n);
    logic [AMT_W-1:0] mask;
    logic [AMT_W-1:0] m;
    mask = AMT_W'(n - 1);
    m    = amt & mask;
    if (dir == SHIFT_LEFT) norm_amt = (AMT_W'(n) - m) & mask;
    else                   norm_amt = m;
  endfunction

endpackage

// File: rtl/shift_req_stage_if.sv
// Request/response bundle between a shift-request producer, the request
// stage and the barrel shifter that consumes the stage output.
//   in_valid/in_ready/in_data/in_amt/in_dir : producer -> stage request
//   out_valid/out_ready/out_data/out_amt    : stage -> shifter head entry
//   count                                   : stage occupancy
// Modports: master = producer/consumer side, slave = the stage itself.
interface shift_req_stage_if
  import shift_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [AMT_W-1:0] out_amt;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, out_amt, count
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, out_amt, count
  );

endinterface

// File: rtl/shift_req_fifo.sv
// Generic first-word-fall-through queue.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push/wdata : write wdata when not full
//   pop        : drop the head entry when not empty
//   rdata      : head entry, forced to zero while empty
//   full/empty : occupancy flags derived from count
//   count      : occupancy 0..DEPTH
// Storage is not reset; pointers and count are.
module shift_req_fifo
  import shift_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two; count alone
  // distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop_ok)  rptr <= rptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // A push presented during reset must not land in storage.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr];
  assign count = cnt;

endmodule

// File: rtl/shift_req_stage.sv
// Upstream request stage for an N-bit barrel shifter. Accepts
// {data, amount, direction} requests, converts each amount to a rotate-right
// count in 0..N-1 on entry, and queues them first-word-fall-through.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : shift_req_stage_if.slave
//                in_* request handshake, out_* head entry for the shifter
//                (out_amt drives shiftAmt), count = occupancy
// in_ready/out_valid/count come from registers only; out_data/out_amt are a
// mux off storage and are zero while the queue is empty.
module shift_req_stage
  import shift_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_req_stage_if.slave bus
);

  localparam int W = N + AMT_W;

  if (!(N == 8 || N == 16 || N == 32)) begin : g_bad_n
    $error("shift_req_stage: N must be 8, 16 or 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("shift_req_stage: DEPTH must be a power of two >= 2");
  end

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [AMT_W-1:0] amt_norm;
  logic [W-1:0]     wdata;
  logic [W-1:0]     rdata;

  // Ready looks only at occupancy, so a full queue refuses a push even in a
  // cycle where the consumer pops.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = !empty && bus.out_ready;

  assign amt_norm = norm_amt(bus.in_amt, shift_dir_t'(bus.in_dir), N);
  assign wdata    = {bus.in_data, amt_norm};

  shift_req_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (bus.count)
  );

  assign bus.out_data = rdata[W-1:AMT_W];
  assign bus.out_amt  = rdata[AMT_W-1:0];

endmodule

// File: tb/tb_shift_req_stage.sv
// Bench for shift_req_stage: an N=8 and an N=16 instance, both DEPTH=4.
// Per-DUT monitors keep a reference queue of accepted requests and compare
// every popped head entry plus the occupancy-derived controls each cycle;
// the scenario tasks add their own directed checks.
module tb_shift_req_stage;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_req_stage_if #(.N(8),  .DEPTH(D)) b8  ();
  shift_req_stage_if #(.N(16), .DEPTH(D)) b16 ();

  shift_req_stage #(.N(8),  .DEPTH(D)) u8  (.clk(clk), .reset(reset), .bus(b8));
  shift_req_stage #(.N(16), .DEPTH(D)) u16 (.clk(clk), .reset(reset), .bus(b16));

  int nvec = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  logic [7:0]  q8d  [$];
  logic [7:0]  q8a  [$];
  logic [15:0] q16d [$];
  logic [7:0]  q16a [$];

  function automatic int exp_amt(int amt, int dir, int n);
    int m;
    m = amt % n;
    if (dir != 0) return (n - m) % n;
    return m;
  endfunction

  // Reference model for the 8-bit instance.
  always @(negedge clk) begin
    int occ;
    logic [7:0] hd, ha;
    if (mon_en) begin
      occ = q8d.size();
      nvec++;
      if (b8.count !== 3'(occ) || b8.in_ready !== (occ < D) || b8.out_valid !== (occ > 0)) begin
        nerr++;
        $display("FAIL mon8_ctrl: count=%0d in_ready=%b out_valid=%b, required count=%0d in_ready=%b out_valid=%b",
                 b8.count, b8.in_ready, b8.out_valid, occ, (occ < D), (occ > 0));
      end
      if (occ == 0) begin
        nvec++;
        if (b8.out_data !== 8'h00 || b8.out_amt !== 8'h00) begin
          nerr++;
          $display("FAIL mon8_idle_zero: data=%h amt=%0d, required 00/0", b8.out_data, b8.out_amt);
        end
      end else if (b8.out_ready === 1'b1) begin
        hd = q8d.pop_front();
        ha = q8a.pop_front();
        nvec++;
        if (b8.out_data !== hd || b8.out_amt !== ha) begin
          nerr++;
          $display("FAIL mon8_pop: data=%h amt=%0d, required data=%h amt=%0d", b8.out_data, b8.out_amt, hd, ha);
        end
      end
      if (reset) begin
        q8d.delete();
        q8a.delete();
      end else if (b8.in_valid === 1'b1 && occ < D) begin
        q8d.push_back(b8.in_data);
        q8a.push_back(8'(exp_amt(int'(b8.in_amt), int'(b8.in_dir), 8)));
      end
    end
  end

  // Reference model for the 16-bit instance.
  always @(negedge clk) begin
    int occ;
    logic [15:0] hd;
    logic [7:0]  ha;
    if (mon_en) begin
      occ = q16d.size();
      nvec++;
      if (b16.count !== 3'(occ) || b16.in_ready !== (occ < D) || b16.out_valid !== (occ > 0)) begin
        nerr++;
        $display("FAIL mon16_ctrl: count=%0d in_ready=%b out_valid=%b, required count=%0d in_ready=%b out_valid=%b",
                 b16.count, b16.in_ready, b16.out_valid, occ, (occ < D), (occ > 0));
      end
      if (occ == 0) begin
        nvec++;
        if (b16.out_data !== 16'h0000 || b16.out_amt !== 8'h00) begin
          nerr++;
          $display("FAIL mon16_idle_zero: data=%h amt=%0d, required 0000/0", b16.out_data, b16.out_amt);
        end
      end else if (b16.out_ready === 1'b1) begin
        hd = q16d.pop_front();
        ha = q16a.pop_front();
        nvec++;
        if (b16.out_data !== hd || b16.out_amt !== ha) begin
          nerr++;
          $display("FAIL mon16_pop: data=%h amt=%0d, required data=%h amt=%0d", b16.out_data, b16.out_amt, hd, ha);
        end
      end
      if (reset) begin
        q16d.delete();
        q16a.delete();
      end else if (b16.in_valid === 1'b1 && occ < D) begin
        q16d.push_back(b16.in_data);
        q16a.push_back(8'(exp_amt(int'(b16.in_amt), int'(b16.in_dir), 16)));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic v, input logic [7:0] d, input logic [7:0] a, input logic dir);
    b8.in_valid = v;
    b8.in_data  = d;
    b8.in_amt   = a;
    b8.in_dir   = dir;
  endtask

  task automatic drv16(input logic v, input logic [15:0] d, input logic [7:0] a, input logic dir);
    b16.in_valid = v;
    b16.in_data  = d;
    b16.in_amt   = a;
    b16.in_dir   = dir;
  endtask

  // Bounded wait for the 8-bit queue to empty (out_ready must be high).
  task automatic drain8();
    for (int k = 0; k < 12; k++) begin
      if (b8.out_valid !== 1'b1) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv8(1'b0, 8'h00, 8'h00, 1'b0);
    drv16(1'b0, 16'h0000, 8'h00, 1'b0);
    b8.out_ready  = 1'b0;
    b16.out_ready = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.count !== 3'd0) begin
      nerr++;
      $display("FAIL reset8_ctrl: out_valid=%b in_ready=%b count=%0d, required 0/1/0", b8.out_valid, b8.in_ready, b8.count);
    end
    nvec++;
    if (b8.out_data !== 8'h00 || b8.out_amt !== 8'h00) begin
      nerr++;
      $display("FAIL reset8_data: data=%h amt=%0d, required 00/0", b8.out_data, b8.out_amt);
    end
    nvec++;
    if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b16.count !== 3'd0 || b16.out_data !== 16'h0) begin
      nerr++;
      $display("FAIL reset16: out_valid=%b in_ready=%b count=%0d data=%h, required 0/1/0/0000",
               b16.out_valid, b16.in_ready, b16.count, b16.out_data);
    end
    tick();
  endtask

  task automatic test_norm8();
    b8.out_ready = 1'b1;
    drv8(1'b1, 8'hA5, 8'd3, 1'b0);
    tick();
    drv8(1'b1, 8'h3C, 8'd3, 1'b1);
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out_data !== 8'hA5 || b8.out_amt !== 8'd3) begin
      nerr++;
      $display("FAIL norm8_0: valid=%b data=%h amt=%0d, required 1/A5/3", b8.out_valid, b8.out_data, b8.out_amt);
    end
    tick();
    drv8(1'b1, 8'hFF, 8'd11, 1'b1);
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out_data !== 8'h3C || b8.out_amt !== 8'd5) begin
      nerr++;
      $display("FAIL norm8_1: valid=%b data=%h amt=%0d, required 1/3C/5", b8.out_valid, b8.out_data, b8.out_amt);
    end
    tick();
    drv8(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out_data !== 8'hFF || b8.out_amt !== 8'd5) begin
      nerr++;
      $display("FAIL norm8_2: valid=%b data=%h amt=%0d, required 1/FF/5", b8.out_valid, b8.out_data, b8.out_amt);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL norm8_empty: out_valid=%b, required 0", b8.out_valid);
    end
    tick();
  endtask

  task automatic test_norm16();
    b16.out_ready = 1'b1;
    drv16(1'b1, 16'h1234, 8'd16, 1'b0);
    tick();
    drv16(1'b1, 16'hABCD, 8'd0, 1'b1);
    @(negedge clk);
    nvec++;
    if (b16.out_data !== 16'h1234 || b16.out_amt !== 8'd0) begin
      nerr++;
      $display("FAIL norm16_0: data=%h amt=%0d, required 1234/0", b16.out_data, b16.out_amt);
    end
    tick();
    drv16(1'b1, 16'h0F0F, 8'd255, 1'b1);
    @(negedge clk);
    nvec++;
    if (b16.out_data !== 16'hABCD || b16.out_amt !== 8'd0) begin
      nerr++;
      $display("FAIL norm16_1: data=%h amt=%0d, required ABCD/0", b16.out_data, b16.out_amt);
    end
    tick();
    drv16(1'b0, 16'h0000, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    if (b16.out_valid !== 1'b1 || b16.out_data !== 16'h0F0F || b16.out_amt !== 8'd1) begin
      nerr++;
      $display("FAIL norm16_2: valid=%b data=%h amt=%0d, required 1/0F0F/1", b16.out_valid, b16.out_data, b16.out_amt);
    end
    tick();
    tick();
    b16.out_ready = 1'b0;
  endtask

  task automatic test_full();
    b8.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv8(1'b1, 8'(8'h10 + i), 8'(i * 7 + 1), 1'(i % 2));
      @(negedge clk);
      nvec++;
      if (b8.in_ready !== 1'b1 || b8.count !== 3'(i)) begin
        nerr++;
        $display("FAIL full_fill%0d: in_ready=%b count=%0d, required 1/%0d", i, b8.in_ready, b8.count, i);
      end
      tick();
    end
    drv8(1'b1, 8'h14, 8'd29, 1'b0);
    repeat (2) begin
      @(negedge clk);
      nvec++;
      if (b8.in_ready !== 1'b0 || b8.count !== 3'd4) begin
        nerr++;
        $display("FAIL full_hold: in_ready=%b count=%0d, required 0/4", b8.in_ready, b8.count);
      end
      tick();
    end
    b8.out_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (b8.in_ready !== 1'b0 || b8.out_data !== 8'h10) begin
      nerr++;
      $display("FAIL full_pop_no_push: in_ready=%b data=%h, required 0/10", b8.in_ready, b8.out_data);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (b8.in_ready !== 1'b1 || b8.count !== 3'd3) begin
      nerr++;
      $display("FAIL full_reopen: in_ready=%b count=%0d, required 1/3", b8.in_ready, b8.count);
    end
    tick();
    drv8(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    if (b8.count !== 3'd3 || b8.out_data !== 8'h12) begin
      nerr++;
      $display("FAIL full_fifth_in: count=%0d data=%h, required 3/12", b8.count, b8.out_data);
    end
    tick();
    drain8();
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b0 || b8.count !== 3'd0) begin
      nerr++;
      $display("FAIL full_drain: out_valid=%b count=%0d, required 0/0", b8.out_valid, b8.count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    b8.out_ready = 1'b0;
    drv8(1'b1, 8'h40, 8'd1, 1'b0);
    tick();
    drv8(1'b1, 8'h41, 8'd2, 1'b1);
    tick();
    b8.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv8(1'b1, 8'(8'h42 + i), 8'(i + 5), 1'(i % 2));
      @(negedge clk);
      nvec++;
      if (b8.count !== 3'd2 || b8.in_ready !== 1'b1 || b8.out_data !== 8'(8'h40 + i)) begin
        nerr++;
        $display("FAIL b2b_%0d: count=%0d in_ready=%b data=%h, required 2/1/%h",
                 i, b8.count, b8.in_ready, b8.out_data, 8'(8'h40 + i));
      end
      tick();
    end
    drv8(1'b0, 8'h00, 8'h00, 1'b0);
    drain8();
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b0 || b8.count !== 3'd0) begin
      nerr++;
      $display("FAIL b2b_drain: out_valid=%b count=%0d, required 0/0", b8.out_valid, b8.count);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    b8.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv8(1'b1, 8'(8'h60 + i), 8'(i + 1), 1'b0);
      tick();
    end
    drv8(1'b1, 8'hEE, 8'd4, 1'b1);
    @(negedge clk);
    nvec++;
    if (b8.count !== 3'd3) begin
      nerr++;
      $display("FAIL flush_pre: count=%0d, required 3", b8.count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv8(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    if (b8.count !== 3'd0 || b8.out_valid !== 1'b0 || b8.out_data !== 8'h00 || b8.out_amt !== 8'h00) begin
      nerr++;
      $display("FAIL flush_post: count=%0d valid=%b data=%h amt=%0d, required 0/0/00/0",
               b8.count, b8.out_valid, b8.out_data, b8.out_amt);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (b8.count !== 3'd0 || b8.out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_dropped: count=%0d valid=%b, required 0/0", b8.count, b8.out_valid);
    end
    tick();
    b8.out_ready = 1'b1;
    drv8(1'b1, 8'h77, 8'd2, 1'b1);
    tick();
    drv8(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    nvec++;
    if (b8.out_valid !== 1'b1 || b8.out_data !== 8'h77 || b8.out_amt !== 8'd6) begin
      nerr++;
      $display("FAIL flush_reuse: valid=%b data=%h amt=%0d, required 1/77/6", b8.out_valid, b8.out_data, b8.out_amt);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_norm8();
    test_norm16();
    test_full();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
